// File: rtl/booth_pkg.sv
// Purpose: shared types and Booth radix-4 digit decode for the sequential MAC.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_POS2,
    DIG_NEG1,
    DIG_NEG2
  } digit_t;

  // trip = {b[2i+1], b[2i], b[2i-1]}
  function automatic digit_t booth_decode(input logic [2:0] trip);
    digit_t d;
    case (trip)
      3'b001, 3'b010: d = DIG_POS1;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Purpose: one radix-4 Booth partial product, shifted, sign-extended and
//          inverted for negative digits (the +1 goes in through the adder cin).
// Latency: combinational.  Backpressure: n/a.
// Ports: a (multiplicand), trip (Booth bit triple), idx (digit index),
//        pp (ACC_W-bit operand for the adder), neg (drives adder cin).
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int ACC_W = 40,
  localparam int IDX_W = $clog2(N / 2)
) (
  input  logic [N-1:0]     a,
  input  logic [2:0]       trip,
  input  logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] pp,
  output logic             neg
);

  digit_t           dig;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] mag;

  assign dig   = booth_decode(trip);
  assign a_ext = {{(ACC_W - N){a[N-1]}}, a};

  always_comb begin
    mag = a_ext << {idx, 1'b0};
    if (dig == DIG_POS2 || dig == DIG_NEG2) begin
      mag = mag << 1;
    end
    neg = (dig == DIG_NEG1) || (dig == DIG_NEG2);
    if (dig == DIG_ZERO) begin
      pp = '0;
    end else if (neg) begin
      pp = ~mag;
    end else begin
      pp = mag;
    end
  end

endmodule

// File: rtl/cla_nbit.sv
// Purpose: W-bit adder, carry lookahead across 4-bit groups.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b (addends), cin (carry in), sum, cout (carry out of the MSB).
module cla_nbit #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic c;
    logic gc;
    logic grp_g;
    logic grp_p;
    c   = cin;
    sum = '0;
    for (int j = 0; j < W; j += 4) begin
      // Group generate/propagate do not depend on the incoming carry, so the
      // carry into the next group is a single G | P & c step.
      grp_g = 1'b0;
      grp_p = 1'b1;
      gc    = c;
      for (int k = 0; k < 4; k++) begin
        if (j + k < W) begin
          sum[j+k] = p[j+k] ^ gc;
          gc       = g[j+k] | (p[j+k] & gc);
          grp_g    = g[j+k] | (p[j+k] & grp_g);
          grp_p    = grp_p & p[j+k];
        end
      end
      c = grp_g | (grp_p & c);
    end
    cout = c;
  end

endmodule

// File: rtl/booth_r4_seq_mac.sv
// Purpose: sequential radix-4 Booth multiply-accumulate, one partial product per clock.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+N/2.
// Backpressure: none; start is ignored while busy (RUN/DONE), never queued.
// Ports: clk, rst_n (sync, active-low), start/acc_en/a/b (request),
//        busy, done (1-cycle), result (signed accumulator), ovf (sticky).
module booth_r4_seq_mac
  import booth_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             acc_en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int              CNT_W = $clog2(N / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N / 2 - 1);

  state_t           state;
  logic [N-1:0]     a_q;
  logic [N:0]       b_q;     // {b, b[-1]=0}
  logic [CNT_W-1:0] cnt;

  logic [2:0]       trip;
  logic [ACC_W-1:0] pp;
  logic             pp_neg;
  logic [ACC_W-1:0] sum;
  logic             cout;
  logic             add_ovf;

  assign trip = b_q[{cnt, 1'b0} +: 3];

  booth_r4_pp_gen #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_pp_gen (
    .a    (a_q),
    .trip (trip),
    .idx  (cnt),
    .pp   (pp),
    .neg  (pp_neg)
  );

  cla_nbit #(
    .W (ACC_W)
  ) u_cla (
    .a    (result),
    .b    (pp),
    .cin  (pp_neg),
    .sum  (sum),
    .cout (cout)
  );

  // Signed overflow: carry into the MSB differs from carry out of it. This is
  // the same as "equal-sign operands, different-sign sum" for the adder's
  // actual operands (inverted pp plus cin for negative digits).
  assign add_ovf = cout ^ (sum[ACC_W-1] ^ result[ACC_W-1] ^ pp[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= {b, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
            if (!acc_en) begin
              result <= '0;
              ovf    <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          // Zero digits still take their cycle so latency never varies.
          result <= sum;
          if (add_ovf) begin
            ovf <= 1'b1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mac.sv
// Purpose: self-checking bench for booth_r4_seq_mac, ACC_W=40 and ACC_W=32 instances.
// Latency: expects done in the 9th cycle after the start cycle (N=16), busy high 9 samples.
// Backpressure: checks that start during RUN/DONE is dropped.
module tb_booth_r4_seq_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0;
  logic        start1;
  logic        acc_en;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy0, done0, ovf0;
  logic [39:0] result0;
  logic        busy1, done1, ovf1;
  logic [31:0] result1;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mac #(.N(16), .ACC_W(40)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start0),
    .acc_en (acc_en),
    .a      (a),
    .b      (b),
    .busy   (busy0),
    .done   (done0),
    .result (result0),
    .ovf    (ovf0)
  );

  booth_r4_seq_mac #(.N(16), .ACC_W(32)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .acc_en (acc_en),
    .a      (a),
    .b      (b),
    .busy   (busy1),
    .done   (done1),
    .result (result1),
    .ovf    (ovf1)
  );

  typedef struct {
    string              nm;
    bit                 sel;     // 0: ACC_W=40, 1: ACC_W=32 (result zero-extended)
    logic signed [15:0] va;
    logic signed [15:0] vb;
    bit                 acc;
    logic [39:0]        exp_res;
    bit                 exp_ovf;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One operation; returns result/ovf captured while done is high, the
  // start-to-done latency in cycles, and how many samples busy/done were high.
  task automatic run_op(input bit sel, input logic [15:0] ta, input logic [15:0] tb_v,
                        input bit ten, output logic [39:0] r, output bit o,
                        output int lat, output int bcnt, output int dcnt);
    bit cb, cd;
    @(negedge clk);
    a = ta; b = tb_v; acc_en = ten;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    r = '0; o = 1'b0; lat = -1; bcnt = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      cb = sel ? busy1 : busy0;
      cd = sel ? done1 : done0;
      if (!cb) break;
      bcnt++;
      if (cd) begin
        dcnt++;
        if (lat < 0) begin
          lat = c + 1;
          r = sel ? {8'h00, result1} : result0;
          o = sel ? ovf1 : ovf0;
        end
      end
    end
  endtask

  initial begin
    logic [39:0] r;
    bit          o;
    int          lat, bcnt, dcnt;

    vt[0]  = '{"10x20",        1'b0, 16'sd10,     16'sd20,     1'b0, 40'd200,          1'b0};
    vt[1]  = '{"-15x5",        1'b0, -16'sd15,    16'sd5,      1'b0, -40'sd75,         1'b0};
    vt[2]  = '{"5x-8",         1'b0, 16'sd5,      -16'sd8,     1'b0, -40'sd40,         1'b0};
    vt[3]  = '{"min_x_min",    1'b0, -16'sd32768, -16'sd32768, 1'b0, 40'd1073741824,   1'b0};
    vt[4]  = '{"max_x_1",      1'b0, 16'sd32767,  16'sd1,      1'b0, 40'd32767,        1'b0};
    vt[5]  = '{"min_x_max",    1'b0, -16'sd32768, 16'sd32767,  1'b0, -40'sd1073709056, 1'b0};
    vt[6]  = '{"1234x4321",    1'b0, 16'sd1234,   16'sd4321,   1'b0, 40'd5332114,      1'b0};
    vt[7]  = '{"acc_-100x50",  1'b0, -16'sd100,   16'sd50,     1'b1, 40'd5327114,      1'b0};
    vt[8]  = '{"30x-10",       1'b0, 16'sd30,     -16'sd10,    1'b0, -40'sd300,        1'b0};
    vt[9]  = '{"w32_min2",     1'b1, -16'sd32768, -16'sd32768, 1'b0, 40'h0040000000,   1'b0};
    vt[10] = '{"w32_acc_ovf",  1'b1, -16'sd32768, -16'sd32768, 1'b1, 40'h0080000000,   1'b1};
    vt[11] = '{"w32_clr_1x1",  1'b1, 16'sd1,      16'sd1,      1'b0, 40'h0000000001,   1'b0};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; acc_en = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0",   40'(busy0), 40'd0);
    chk("rst_done0",   40'(done0), 40'd0);
    chk("rst_result0", result0,    40'd0);
    chk("rst_ovf0",    40'(ovf0),  40'd0);
    chk("rst_busy1",   40'(busy1), 40'd0);
    chk("rst_result1", 40'(result1), 40'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].sel, vt[i].va, vt[i].vb, vt[i].acc, r, o, lat, bcnt, dcnt);
      chk({vt[i].nm, "_result"},  r,          vt[i].exp_res);
      chk({vt[i].nm, "_ovf"},     40'(o),     40'(vt[i].exp_ovf));
      chk({vt[i].nm, "_latency"}, 40'(lat),   40'd9);
      chk({vt[i].nm, "_busy"},    40'(bcnt),  40'd9);
      chk({vt[i].nm, "_donew"},   40'(dcnt),  40'd1);
      @(negedge clk);
      chk({vt[i].nm, "_hold"}, vt[i].sel ? {8'h00, result1} : result0, vt[i].exp_res);
    end

    // start pulses during RUN cycle 3 and during DONE must be dropped.
    @(negedge clk);
    a = 16'd10; b = 16'd20; acc_en = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    r = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) begin
        a = 16'd7; b = 16'd7; acc_en = 1'b1; start0 = 1'b1;
      end else if (c == 3) begin
        start0 = 1'b0;
      end
      if (done0) begin
        r = result0;
        start0 = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start0 = 1'b0;
    chk("ign_result",      r,           40'd200);
    chk("ign_busy_after",  40'(busy0),  40'd0);
    chk("ign_result_hold", result0,     40'd200);
    run_op(1'b0, 16'd7, 16'd7, 1'b1, r, o, lat, bcnt, dcnt);
    chk("after_ign_result",  r,        40'd249);
    chk("after_ign_latency", 40'(lat), 40'd9);

    // Reset low for the 4th RUN edge aborts the operation.
    @(negedge clk);
    a = 16'd1234; b = 16'd4321; acc_en = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",   40'(busy0), 40'd0);
    chk("abort_done",   40'(done0), 40'd0);
    chk("abort_result", result0,    40'd0);
    chk("abort_ovf",    40'(ovf0),  40'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 40'(busy0), 40'd0);
    run_op(1'b0, 16'd30, -16'sd10, 1'b0, r, o, lat, bcnt, dcnt);
    chk("post_abort_result",  r,         -40'sd300);
    chk("post_abort_latency", 40'(lat),  40'd9);
    chk("post_abort_busy",    40'(bcnt), 40'd9);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
